pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 16 +
 rtl/pipe_skid_reg_if.sv | 27 ++
 rtl/pipe_sat_counter.sv | 24 ++
 rtl/pipe_skid_reg.sv | 131 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg -- shared types and constants for the pipeline skid register.
//   state_e : fill state of the register (EMPTY / BUSY / FULL)
//   OCC_W   : width of the occupancy report (counts 0..2 held entries)
//   ID_EX_W : payload width of the ID/EX bundle, the default payload width
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int OCC_W   = 2;
  localparam int ID_EX_W = 42;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if -- valid/ready handshake bundle around one pipeline register.
//   in_valid/in_ready/in_data    : upstream side (producer -> register)
//   out_valid/out_ready/out_data : downstream side (register -> consumer)
//   modport slave  : the register itself
//   modport master : the surrounding stages (or a testbench) driving it
interface pipe_skid_reg_if import pipe_skid_reg_pkg::*; #(
  parameter int PAYLOAD_W = ID_EX_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter -- saturating up-counter.
//   clk    : clock, counts on rising edge
//   reset  : asynchronous, active-low clear
//   enable : count this cycle
//   count  : current value, sticks at all-ones instead of wrapping
module pipe_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles; once all-ones is reached the value is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- pipeline register with valid/ready handshake.
//   SKID=1 : two-entry skid buffer (main + skid), in_ready is a flop output
//   SKID=0 : single entry, in_ready = !out_valid || out_ready
// Ports:
//   clk, reset (async, active-low)
//   bus       : handshake bundle (slave side)
//   flush     : synchronous kill of all held entries
//   occupancy : number of held entries (0..2)
//   stall_cnt : saturating count of cycles with out_valid=1, out_ready=0
module pipe_skid_reg import pipe_skid_reg_pkg::*; #(
  parameter int PAYLOAD_W = ID_EX_W,
  parameter int SKID      = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  pipe_skid_reg_if.slave   bus,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, skid_q;
  logic                 rdy_q;
  logic                 in_ready, out_valid;
  logic                 in_xfer, out_xfer;
  logic                 load_main, load_skid, skid_to_main;

  assign out_valid = (state_q != EMPTY);

  // In SKID=0 mode rdy_q only says "out of reset"; readiness then follows
  // the downstream side combinationally.
  assign in_ready = (SKID != 0) ? rdy_q : (rdy_q && (!out_valid || bus.out_ready));

  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;

  // Next-state and data-steering decisions. Flush wins over everything and
  // leaves the data registers untouched, so an input accepted alongside a
  // flush is simply dropped.
  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d   = BUSY;
            load_main = 1'b1;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer && (SKID != 0)) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d      = BUSY;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register plus the registered ready; ready is computed from the
  // next state so it is valid in the same cycle the state is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  // Payload registers only change when a payload is accepted or moves up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= bus.in_data;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= bus.in_data;
      end
    end
  end

  // Occupancy decoded straight from the state.
  always_comb begin
    occupancy = '0;
    unique case (state_q)
      EMPTY:   occupancy = OCC_W'(0);
      BUSY:    occupancy = OCC_W'(1);
      FULL:    occupancy = OCC_W'(2);
      default: occupancy = OCC_W'(0);
    endcase
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (out_valid && !bus.out_ready),
    .count  (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg -- self-checking bench for pipe_skid_reg.
//   dut_a : SKID=1, CNT_W=3 -- directed vector table plus hand-written
//           reset-while-full and stall-saturation sequences
//   dut_b : SKID=0, CNT_W=8 -- randomised traffic against a queue model
module tb_pipe_skid_reg;

  localparam int PW = 42;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_skid_reg_if #(.PAYLOAD_W(PW)) bus_a ();
  pipe_skid_reg_if #(.PAYLOAD_W(PW)) bus_b ();

  logic       flush_a, flush_b;
  logic [1:0] occ_a, occ_b;
  logic [2:0] stall_a;
  logic [7:0] stall_b;

  pipe_skid_reg #(.PAYLOAD_W(PW), .SKID(1), .CNT_W(3)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a),
    .flush     (flush_a),
    .occupancy (occ_a),
    .stall_cnt (stall_a)
  );

  pipe_skid_reg #(.PAYLOAD_W(PW), .SKID(0), .CNT_W(8)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b),
    .flush     (flush_b),
    .occupancy (occ_b),
    .stall_cnt (stall_b)
  );

  typedef struct {
    logic          iv;
    logic [PW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          e_rdy;
    logic          e_ov;
    logic [PW-1:0] e_od;
    logic [1:0]    e_occ;
    logic [2:0]    e_st;
  } vec_t;

  vec_t vecs [23];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(int iv, longint d, int ordy, int fl,
                              int erdy, int eov, longint eod, int eocc, int est);
    vec_t v;
    v.iv    = iv[0];
    v.d     = PW'(d);
    v.ordy  = ordy[0];
    v.fl    = fl[0];
    v.e_rdy = erdy[0];
    v.e_ov  = eov[0];
    v.e_od  = PW'(eod);
    v.e_occ = 2'(eocc);
    v.e_st  = 3'(est);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [PW-1:0] d,
                               input logic ordy, input logic fl);
    bus_a.in_valid  = iv;
    bus_a.in_data   = d;
    bus_a.out_ready = ordy;
    flush_a         = fl;
  endtask

  task automatic checkA(input string tag, input logic rdy, input logic ov,
                        input logic [PW-1:0] od, input logic [1:0] occ);
    checkOutput({tag, "_rdy"}, 64'(bus_a.in_ready),  64'(rdy));
    checkOutput({tag, "_ov"},  64'(bus_a.out_valid), 64'(ov));
    checkOutput({tag, "_od"},  64'(bus_a.out_data),  64'(od));
    checkOutput({tag, "_occ"}, 64'(occ_a),           64'(occ));
  endtask

  // Directed SKID=1 sequence, then the SKID=0 random run.
  initial begin
    logic [PW-1:0] q [$];
    logic [PW-1:0] b_main;
    logic          iv, ordy, fl, e_ov, e_rdy, push, pop;
    logic [PW-1:0] d;
    int            b_stall;

    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.out_ready = 1'b0;
    flush_b         = 1'b0;

    // ---- reset state ----
    #2;
    checkA("reset", 1'b0, 1'b0, '0, 2'd0);
    checkOutput("reset_stall_a", 64'(stall_a), 64'(0));
    checkOutput("reset_rdy_b",   64'(bus_b.in_ready),  64'(0));
    checkOutput("reset_ov_b",    64'(bus_b.out_valid), 64'(0));
    checkOutput("reset_occ_b",   64'(occ_b),           64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("release_rdy_a", 64'(bus_a.in_ready), 64'(0));
    checkOutput("release_rdy_b", 64'(bus_b.in_ready), 64'(0));
    @(posedge clk);
    #1;

    // ---- vector table (iv,d,ordy,fl | rdy,ov,od,occ,stall) ----
    vecs[0]  = mk(1, 'h0AA, 1, 0,  1, 0, 'h000, 0, 0);
    vecs[1]  = mk(1, 'h0AA, 1, 0,  1, 1, 'h0AA, 1, 0);
    vecs[2]  = mk(1, 'h0AA, 1, 0,  1, 1, 'h0AA, 1, 0);
    vecs[3]  = mk(1, 'h0AA, 1, 0,  1, 1, 'h0AA, 1, 0);
    vecs[4]  = mk(0, 'h000, 1, 0,  1, 1, 'h0AA, 1, 0);
    vecs[5]  = mk(0, 'h000, 0, 0,  1, 0, 'h0AA, 0, 0);
    vecs[6]  = mk(1, 'h111, 0, 0,  1, 0, 'h0AA, 0, 0);
    vecs[7]  = mk(1, 'h222, 0, 0,  1, 1, 'h111, 1, 0);
    vecs[8]  = mk(1, 'h333, 0, 0,  0, 1, 'h111, 2, 1);
    vecs[9]  = mk(1, 'h333, 1, 0,  0, 1, 'h111, 2, 2);
    vecs[10] = mk(1, 'h333, 1, 0,  1, 1, 'h222, 1, 2);
    vecs[11] = mk(0, 'h000, 1, 0,  1, 1, 'h333, 1, 2);
    vecs[12] = mk(0, 'h000, 0, 0,  1, 0, 'h333, 0, 2);
    vecs[13] = mk(1, 'h444, 0, 0,  1, 0, 'h333, 0, 2);
    vecs[14] = mk(1, 'h555, 0, 0,  1, 1, 'h444, 1, 2);
    vecs[15] = mk(1, 'h666, 0, 1,  0, 1, 'h444, 2, 3);
    vecs[16] = mk(1, 'h777, 0, 0,  1, 0, 'h444, 0, 4);
    vecs[17] = mk(1, 'h888, 1, 1,  1, 1, 'h777, 1, 4);
    vecs[18] = mk(0, 'h000, 1, 0,  1, 0, 'h777, 0, 4);
    vecs[19] = mk(0, 'h000, 0, 0,  1, 0, 'h777, 0, 4);
    vecs[20] = mk(1, 'h999, 0, 0,  1, 0, 'h777, 0, 4);
    vecs[21] = mk(1, 'hABC, 0, 1,  1, 1, 'h999, 1, 4);
    vecs[22] = mk(0, 'h000, 0, 0,  1, 0, 'h999, 0, 5);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      @(negedge clk);
      checkA($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_occ);
      checkOutput($sformatf("row%0d_stall", i), 64'(stall_a), 64'(vecs[i].e_st));
      @(posedge clk);
      #1;
    end

    // ---- reset pulse while FULL: outputs clear before any edge ----
    applyStimulus(1'b1, PW'(64'h1), 1'b0, 1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b1, PW'(64'h2), 1'b0, 1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_occ", 64'(occ_a), 64'(2));
    #2 reset = 1'b0;
    #1;
    checkA("async_rst", 1'b0, 1'b0, '0, 2'd0);
    checkOutput("async_rst_stall", 64'(stall_a), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rerelease_rdy", 64'(bus_a.in_ready), 64'(0));
    @(posedge clk);
    #1;
    checkA("post_rst", 1'b1, 1'b0, '0, 2'd0);

    // ---- stall counter saturation at 7 ----
    applyStimulus(1'b1, PW'(64'h5A), 1'b0, 1'b0);
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("sat_k%0d", k), 64'(stall_a), 64'((k > 7) ? 7 : k));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("sat_held", 64'(stall_a), 64'(7));
    checkA("sat_data", 1'b1, 1'b1, PW'(64'h5A), 2'd1);
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("drain_ov", 64'(bus_a.out_valid), 64'(0));
    checkOutput("drain_stall", 64'(stall_a), 64'(7));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // ---- SKID=0 random traffic against a queue model ----
    b_main  = '0;
    b_stall = 0;
    for (int c = 0; c < 10000; c++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      d    = PW'({$urandom(), $urandom()});
      bus_b.in_valid  = iv;
      bus_b.in_data   = d;
      bus_b.out_ready = ordy;
      flush_b         = fl;
      @(negedge clk);
      e_ov  = (q.size() != 0);
      e_rdy = !e_ov || ordy;
      checkOutput($sformatf("b_sb_c%0d", c),
                  64'({bus_b.in_ready, bus_b.out_valid, occ_b, bus_b.out_data}),
                  64'({e_rdy, e_ov, 2'(q.size()), b_main}));
      push = iv && e_rdy;
      pop  = e_ov && ordy;
      if (e_ov && !ordy && b_stall < 255) b_stall++;
      @(posedge clk);
      if (fl) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back(d);
          b_main = d;
        end
      end
      #1;
      if (bad > 40) break;
    end
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;
    flush_b         = 1'b0;
    checkOutput("b_stall", 64'(stall_b), 64'(b_stall));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
